// File: rtl/decrementor_if.sv
// Operand/result bundle for the decrementor: operand, capture strobe and results.
// Latency: none; the interface only carries wires.
// Backpressure: none; the capture strobe is fire-and-forget.
interface decrementor_if #(
    parameter int N = 4
);
    logic [N-1:0] i_in;
    logic         i_en;
    logic [N-1:0] o_out;
    logic         o_underflow;
    logic         o_zero;
    logic [N-1:0] o_out_q;
    logic         o_underflow_q;
    logic         o_zero_q;
    logic         o_valid_q;

    // Driver side: supplies the operand and strobe, observes the results.
    modport master (
        output i_in, i_en,
        input  o_out, o_underflow, o_zero,
        input  o_out_q, o_underflow_q, o_zero_q, o_valid_q
    );

    // Decrementor side.
    modport slave (
        input  i_in, i_en,
        output o_out, o_underflow, o_zero,
        output o_out_q, o_underflow_q, o_zero_q, o_valid_q
    );
endinterface

// File: rtl/decrementor.sv
// N-bit unsigned decrementor (wrap or clamp at 0) with status flags and a registered copy.
// Latency: combinational outputs in zero cycles, _q outputs one clock after en.
// Backpressure: none; en is a capture strobe and is never stalled.
module decrementor #(
    parameter int N        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    decrementor_if.slave   bus
);
    logic [N:0]   w_borrow;
    logic [N-1:0] w_diff;
    logic [N-1:0] w_out;
    logic         w_underflow;
    logic         w_zero;

    logic [N-1:0] r_out_q;
    logic         r_underflow_q;
    logic         r_zero_q;
    logic         r_valid_q;

    // Subtracting one means injecting a borrow at the LSB; it keeps rippling
    // upward only through zero bits, and flips every bit it passes.
    assign w_borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_borrow_cell
            assign w_diff[gi]       = bus.i_in[gi] ^ w_borrow[gi];
            assign w_borrow[gi + 1] = w_borrow[gi] & ~bus.i_in[gi];
        end
    endgenerate

    // A borrow escaping the top bit means every input bit was zero.
    assign w_underflow = w_borrow[N];

    // In clamp mode the wrapped all-ones result is replaced by zero.
    assign w_out  = (SATURATE && w_underflow) ? '0 : w_diff;
    assign w_zero = ~(|w_out);

    assign bus.o_out       = w_out;
    assign bus.o_underflow = w_underflow;
    assign bus.o_zero      = w_zero;

    // Capture result and flags on en; valid pulses for one cycle per capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_q       <= '0;
            r_underflow_q <= 1'b0;
            r_zero_q      <= 1'b0;
            r_valid_q     <= 1'b0;
        end else begin
            r_valid_q <= bus.i_en;
            if (bus.i_en) begin
                r_out_q       <= w_out;
                r_underflow_q <= w_underflow;
                r_zero_q      <= w_zero;
            end
        end
    end

    assign bus.o_out_q       = r_out_q;
    assign bus.o_underflow_q = r_underflow_q;
    assign bus.o_zero_q      = r_zero_q;
    assign bus.o_valid_q     = r_valid_q;
endmodule

// File: tb/tb_decrementor.sv
// Self-checking bench for decrementor across four configurations.
// Latency: checks combinational outputs after settling and _q outputs 1 unit after each edge.
// Backpressure: none exercised; the design has no stall path.
module tb_decrementor;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    // sel 0: N=4 wrap, 1: N=4 clamp, 2: N=1 wrap, 3: N=8 wrap
    decrementor_if #(.N(4)) if4  ();
    decrementor_if #(.N(4)) if4s ();
    decrementor_if #(.N(1)) if1  ();
    decrementor_if #(.N(8)) if8  ();

    decrementor #(.N(4), .SATURATE(1'b0)) u_dec4  (.clk(clk), .rst(rst), .bus(if4.slave));
    decrementor #(.N(4), .SATURATE(1'b1)) u_dec4s (.clk(clk), .rst(rst), .bus(if4s.slave));
    decrementor #(.N(1), .SATURATE(1'b0)) u_dec1  (.clk(clk), .rst(rst), .bus(if1.slave));
    decrementor #(.N(8), .SATURATE(1'b0)) u_dec8  (.clk(clk), .rst(rst), .bus(if8.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         sel;
        logic [7:0] in;
        logic [7:0] exp_out;
        logic       exp_uf;
        logic       exp_zero;
    } vec_t;

    function automatic int width_of(int sel);
        case (sel)
            2:       return 1;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    // Reference: value minus one, either wrapping to 2^n-1 or clamping at 0.
    function automatic logic [7:0] ref_out(int n, bit sat, int v);
        int r;
        if (v == 0) r = sat ? 0 : (1 << n) - 1;
        else        r = v - 1;
        return r[7:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(int sel, logic [7:0] v);
        case (sel)
            0:       if4.i_in  = v[3:0];
            1:       if4s.i_in = v[3:0];
            2:       if1.i_in  = v[0:0];
            default: if8.i_in  = v;
        endcase
    endtask

    task automatic set_en(logic e);
        if4.i_en  = e;
        if4s.i_en = e;
        if1.i_en  = e;
        if8.i_en  = e;
    endtask

    task automatic get_comb(int sel, output logic [7:0] o, output logic uf, output logic z);
        case (sel)
            0:       begin o = {4'b0, if4.o_out};  uf = if4.o_underflow;  z = if4.o_zero;  end
            1:       begin o = {4'b0, if4s.o_out}; uf = if4s.o_underflow; z = if4s.o_zero; end
            2:       begin o = {7'b0, if1.o_out};  uf = if1.o_underflow;  z = if1.o_zero;  end
            default: begin o = if8.o_out;          uf = if8.o_underflow;  z = if8.o_zero;  end
        endcase
    endtask

    task automatic check_q4(string tag, logic [3:0] eo, logic eu, logic ez, logic ev);
        check({tag, "_out_q"},  {28'b0, if4.o_out_q},       {28'b0, eo});
        check({tag, "_uf_q"},   {31'b0, if4.o_underflow_q}, {31'b0, eu});
        check({tag, "_zero_q"}, {31'b0, if4.o_zero_q},      {31'b0, ez});
        check({tag, "_vld_q"},  {31'b0, if4.o_valid_q},     {31'b0, ev});
    endtask

    initial begin
        vec_t       vecs[13];
        logic [7:0] o;
        logic       uf;
        logic       z;
        logic [3:0] m_out;
        logic       m_uf;
        logic       m_zero;
        logic       m_vld;
        logic [3:0] s_out;

        total = 0;
        bad   = 0;
        vecs[0]  = '{0, 8'd1,   8'd0,   1'b0, 1'b1};
        vecs[1]  = '{0, 8'd2,   8'd1,   1'b0, 1'b0};
        vecs[2]  = '{0, 8'd0,   8'd15,  1'b1, 1'b0};
        vecs[3]  = '{0, 8'd15,  8'd14,  1'b0, 1'b0};
        vecs[4]  = '{1, 8'd0,   8'd0,   1'b1, 1'b1};
        vecs[5]  = '{1, 8'd5,   8'd4,   1'b0, 1'b0};
        vecs[6]  = '{1, 8'd1,   8'd0,   1'b0, 1'b1};
        vecs[7]  = '{2, 8'd0,   8'd1,   1'b1, 1'b0};
        vecs[8]  = '{2, 8'd1,   8'd0,   1'b0, 1'b1};
        vecs[9]  = '{3, 8'd0,   8'd255, 1'b1, 1'b0};
        vecs[10] = '{3, 8'd128, 8'd127, 1'b0, 1'b0};
        vecs[11] = '{3, 8'd255, 8'd254, 1'b0, 1'b0};
        vecs[12] = '{3, 8'd1,   8'd0,   1'b0, 1'b1};

        rst = 1'b0;
        set_en(1'b0);
        for (int s = 0; s < 4; s++) set_in(s, 8'd0);

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_q4("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_async_vld_sat", {31'b0, if4s.o_valid_q}, 32'd0);
        check("rst_async_out8", {24'b0, if8.o_out_q}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Directed combinational vectors.
        for (int k = 0; k < 13; k++) begin
            set_in(vecs[k].sel, vecs[k].in);
            #10;
            get_comb(vecs[k].sel, o, uf, z);
            check($sformatf("vec%0d_out", k),  {24'b0, o},  {24'b0, vecs[k].exp_out});
            check($sformatf("vec%0d_uf", k),   {31'b0, uf}, {31'b0, vecs[k].exp_uf});
            check($sformatf("vec%0d_zero", k), {31'b0, z},  {31'b0, vecs[k].exp_zero});
        end

        // Exhaustive sweep of the 4-bit wrap instance.
        for (int v = 0; v < 16; v++) begin
            set_in(0, v[7:0]);
            #10;
            get_comb(0, o, uf, z);
            check($sformatf("sweep%0d_out", v), {24'b0, o}, (v + 15) % 16);
            check($sformatf("sweep%0d_uf", v),  {31'b0, uf}, (v == 0) ? 32'd1 : 32'd0);
        end

        // Random combinational checks on all instances.
        for (int k = 0; k < 120; k++) begin
            int sel;
            int v;
            logic [7:0] e;
            sel = $urandom_range(0, 3);
            v   = $urandom_range(0, (1 << width_of(sel)) - 1);
            set_in(sel, v[7:0]);
            #3;
            get_comb(sel, o, uf, z);
            e = ref_out(width_of(sel), sel == 1, v);
            check($sformatf("rnd_s%0d_v%0d_out", sel, v), {24'b0, o}, {24'b0, e});
            check($sformatf("rnd_s%0d_v%0d_uf", sel, v), {31'b0, uf}, (v == 0) ? 32'd1 : 32'd0);
            check($sformatf("rnd_s%0d_v%0d_zero", sel, v), {31'b0, z}, (e == 0) ? 32'd1 : 32'd0);
        end

        // Registered path: capture then hold.
        @(negedge clk);
        set_in(0, 8'd9);
        set_en(1'b1);
        @(posedge clk); #1;
        check_q4("cap9", 4'd8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_en(1'b0);
        set_in(0, 8'd3);
        @(posedge clk); #1;
        check_q4("hold9", 4'd8, 1'b0, 1'b0, 1'b0);

        // Reset between edges with a capture pending, then an edge under reset.
        @(negedge clk);
        set_in(0, 8'd0);
        set_in(1, 8'd0);
        set_en(1'b1);
        #2 rst = 1'b1;
        #1;
        check_q4("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_q4("rst_edge", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_q4("post_rst", 4'd15, 1'b1, 1'b0, 1'b1);
        check("post_rst_sat_out_q",  {28'b0, if4s.o_out_q},       32'd0);
        check("post_rst_sat_uf_q",   {31'b0, if4s.o_underflow_q}, 32'd1);
        check("post_rst_sat_zero_q", {31'b0, if4s.o_zero_q},      32'd1);

        // Random capture/hold traffic against a last-captured-value model.
        m_out  = 4'd15;
        m_uf   = 1'b1;
        m_zero = 1'b0;
        s_out  = 4'd0;
        for (int k = 0; k < 200; k++) begin
            int  v;
            int  vs;
            logic e;
            @(negedge clk);
            v  = $urandom_range(0, 15);
            vs = $urandom_range(0, 15);
            e  = ($urandom_range(0, 2) != 0);
            set_in(0, v[7:0]);
            set_in(1, vs[7:0]);
            set_en(e);
            if (e) begin
                m_out  = ref_out(4, 1'b0, v);
                m_uf   = (v == 0);
                m_zero = (m_out == 0);
                s_out  = ref_out(4, 1'b1, vs);
            end
            m_vld = e;
            @(posedge clk); #1;
            check_q4($sformatf("seq%0d", k), m_out, m_uf, m_zero, m_vld);
            check($sformatf("seq%0d_sat_out_q", k), {28'b0, if4s.o_out_q}, {28'b0, s_out});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decrementor.md
Name: decrementor

Overview:
- Parameterised N-bit unsigned decrementor: combinational path computes in - 1 modulo 2^N, alongside a registered copy of the result and its status flags.
- Used as an arithmetic leaf (counters, address/index stepping) wherever a value-minus-one is needed either immediately or one clock later.
- Combinational result is implemented as an explicit ripple-borrow chain: one borrow cell per bit, built with generate.

Parameters:
- N, 4, data width in bits (N >= 1).
- SATURATE, 0, 0 = wrap-around (0 -> 2^N-1); 1 = clamp at 0 (0 -> 0).

Ports:
- clk  input  1  single system clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  N  unsigned operand.
- en  input  1  capture strobe for the registered stage.
- out  output  N  combinational result: in - 1 (see SATURATE).
- underflow  output  1  combinational; 1 when in == 0.
- zero  output  1  combinational; 1 when out == 0, i.e. in == 1, or in == 0 with SATURATE=1.
- out_q  output  N  registered out.
- underflow_q  output  1  registered underflow.
- zero_q  output  1  registered zero.
- valid_q  output  1  1 for exactly one cycle after a cycle with en=1.

Behaviour:
- Combinational path (no clock dependency; settles within the same delta/time step as in changes):
  - borrow[0] = 1; out[i] = in[i] XOR borrow[i]; borrow[i+1] = borrow[i] AND NOT in[i].
  - underflow = borrow[N] (all input bits zero).
- SATURATE=0 (default): out = (in - 1) mod 2^N. Boundary: in = 0 -> out = all ones (N=4: 4'b1111), underflow = 1.
- SATURATE=1: when underflow = 1, out is forced to 0 and zero = 1; otherwise identical to wrap mode.
- Maximum input: in = 2^N-1 -> out = 2^N-2, underflow = 0.
- out is fully defined for every input; no X propagation for known inputs.
- Registered stage:
  - On rising clk with en=1: out_q <= out, underflow_q <= underflow, zero_q <= zero, valid_q <= 1.
  - On rising clk with en=0: out_q, underflow_q and zero_q hold their values; valid_q <= 0.
  - Latency from in/en to the registered outputs is one clock.
- Reset:
  - rst=1 asynchronously forces out_q = 0, underflow_q = 0, zero_q = 0, valid_q = 0, immediately and independent of clk.
  - While rst is high, en is ignored.
  - On the first rising edge after rst deasserts, normal capture resumes.
  - Reset mid-operation discards any pending capture; no partial update.
  - Combinational outputs are unaffected by rst.
- Simultaneous events: rst asserted on the same edge as en=1 -> reset wins, registers = 0.
- Width rules:
  - No carry/borrow output beyond underflow.
  - out width always equals N.
  - N=1 degenerates to out = NOT in (wrap mode).

Test Plan:
- N=4, SATURATE=0, combinational: in=1 -> out=0, zero=1, underflow=0; in=2 -> out=1, zero=0; in=0 -> out=15, underflow=1; in=15 -> out=14. Check 10 time units after each change, no clock edges required.
- Exhaustive sweep of in = 0..15 -> out == (in+15)%16 every value; underflow high only at in=0.
- SATURATE=1: in=0 -> out=0, zero=1, underflow=1; in=5 -> out=4.
- Registered path: rst pulse -> all _q outputs 0 before any clk edge. Then in=9, en=1, one clk edge -> out_q=8, valid_q=1. Next edge with en=0 -> out_q stays 8, valid_q=0.
- Reset priority: en=1, in=0, rst asserted between edges -> _q outputs drop to 0 at once. Edge while rst high -> still 0. After release, edge with en=1 -> out_q=15, underflow_q=1.
- Parameter sweep N=1 and N=8: N=1: in=0 -> out=1, in=1 -> out=0. N=8: in=0 -> out=255, in=128 -> out=127.
